// File: rtl/count_sequencer_if.sv
// Bundle of control inputs and count/status outputs for count_sequencer.
// master drives the controls; slave is the sequencer itself.
interface count_sequencer_if #(
  parameter int WIDTH = 4
);
  // No valid/ready pair here: every control is sampled on each rising CLOCK edge,
  // start/stop/cfg_we act as one-cycle requests, pause is a level, and every
  // output is valid on every cycle.
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic             cfg_we;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;
  logic             done;
  logic [3:0]       pass_cnt;
  logic [1:0]       state_dbg;

  modport master (
    output start, stop, pause, mode, cfg_we, limit,
    input  Q, busy, tc, done, pass_cnt, state_dbg
  );

  modport slave (
    input  start, stop, pause, mode, cfg_we, limit,
    output Q, busy, tc, done, pass_cnt, state_dbg
  );
endinterface

// File: rtl/count_sequencer.sv
// Run controller for the 4-bit counter: start/pause/stop sequencing,
// one-shot or periodic operation against a programmable limit.
module count_sequencer #(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(9)
) (
  input  logic              CLOCK,
  input  logic              CLEAR,
  count_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] limit_reg, limit_reg_n;
  logic [3:0]       pass_cnt, pass_cnt_n;
  logic             tc, tc_n;
  logic             done, done_n;

  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      state     <= IDLE;
      q         <= '0;
      limit_reg <= DEFAULT_LIMIT;
      pass_cnt  <= 4'd0;
      tc        <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      limit_reg <= limit_reg_n;
      pass_cnt  <= pass_cnt_n;
      tc        <= tc_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    q_n         = q;
    limit_reg_n = limit_reg;
    pass_cnt_n  = pass_cnt;
    tc_n        = 1'b0;
    done_n      = done;

    unique case (state)
      IDLE, DONE: begin
        // The limit is written at the same edge a run starts, so it governs that run.
        if (bus.cfg_we) limit_reg_n = bus.limit;
        if (bus.start && !bus.stop) begin
          state_n    = RUN;
          q_n        = '0;
          done_n     = 1'b0;
          pass_cnt_n = 4'd0;
        end else if (bus.stop && state == DONE) begin
          state_n = IDLE;
          done_n  = 1'b0;
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_n = IDLE;
          q_n     = '0;
        end else if (bus.pause) begin
          state_n = PAUSE;
        end else if (q == limit_reg) begin
          tc_n       = 1'b1;
          pass_cnt_n = (pass_cnt == 4'd15) ? pass_cnt : pass_cnt + 4'd1;
          if (bus.mode) begin
            q_n = '0;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          q_n = q + WIDTH'(1);
        end
      end

      PAUSE: begin
        if (bus.stop) begin
          state_n = IDLE;
          q_n     = '0;
        end else if (!bus.pause) begin
          state_n = RUN;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.Q         = q;
  assign bus.busy      = (state == RUN) || (state == PAUSE);
  assign bus.tc        = tc;
  assign bus.done      = done;
  assign bus.pass_cnt  = pass_cnt;
  assign bus.state_dbg = state;

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Run controller for the team's 4-bit ripple counter datapath. Owns the count register and sequences it through start, pause, stop and terminal-count events. Supports one-shot and periodic (auto-reload) modes against a programmable limit. Sits between system control logic and anything consuming the count value or terminal pulse.

Parameters:
WIDTH, 4, width of count value Q and limit.
DEFAULT_LIMIT, 4'd9, limit_reg value loaded at reset.

Ports:
CLOCK  input  1  single clock; all state changes on rising edge.
CLEAR  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
start  input  1  begin a count run; sampled in IDLE or DONE only.
stop  input  1  abort the run; returns to IDLE.
pause  input  1  level; while 1 in RUN, the count holds.
mode  input  1  0 = one-shot, 1 = periodic; sampled every cycle in RUN.
cfg_we  input  1  write limit into limit_reg.
limit  input  WIDTH  terminal count value.
Q  output  WIDTH  current count.
busy  output  1  1 in RUN or PAUSE.
tc  output  1  one-cycle terminal-count pulse.
done  output  1  one-shot completion flag; level.
pass_cnt  output  4  completed periods since last start; saturates at 15.

Behaviour:
- Reset (CLEAR=0, async): state=IDLE, Q=0, busy=0, tc=0, done=0, pass_cnt=0, limit_reg=DEFAULT_LIMIT. Reset mid-run aborts with no tc.
- All outputs are registered. busy is decoded from the registered state.
- States: IDLE, RUN, PAUSE, DONE.
- Priority within a cycle: stop > start > pause > count/terminal.
- IDLE/DONE:
  - cfg_we=1: limit_reg<=limit at the edge.
  - cfg_we is ignored in RUN/PAUSE.
  - start=1 and stop=0: next state RUN, Q<=0, done<=0, pass_cnt<=0, tc<=0.
  - start=1 with stop=1: stay in current state. From DONE this becomes IDLE, with done<=0.
  - cfg_we and start in the same cycle: the new limit applies to this run.
- RUN, per edge:
  - stop=1: IDLE, Q<=0, tc<=0.
  - else pause=1: PAUSE, Q holds, tc<=0.
  - else Q==limit_reg (terminal):
    - tc<=1.
    - pass_cnt<=pass_cnt+1, saturating at 15.
    - mode=1: Q<=0, stay in RUN.
    - mode=0: Q holds at limit_reg, done<=1, go to DONE.
  - else: Q<=Q+1, tc<=0.
- PAUSE:
  - stop=1: IDLE, Q<=0.
  - pause=0: RUN. Q unchanged this edge; counting resumes next edge.
  - else hold.
  - tc is always 0 in PAUSE.
- Terminal coinciding with pause: pause wins, tc is deferred until counting resumes. Terminal coinciding with stop: stop wins, no tc, pass_cnt unchanged.
- Period: limit_reg+1 counting cycles.
  - limit_reg=0: Q stays 0; tc fires on the first RUN edge, then every edge in periodic mode.
  - limit_reg=15: Q wraps 15->0 only through the terminal path, never by overflow.
- tc is high for exactly one cycle per terminal event, except back-to-back in periodic mode with limit 0.
- DONE: Q and done hold until start, stop or reset. tc=0.
- start asserted in RUN or PAUSE is ignored.

Test Plan:
- Reset then one-shot: CLEAR=0 for 34 ns, then 1. limit=9, mode=0, start for 1 cycle -> Q counts 0..9 over 10 edges; tc high exactly 1 cycle; done=1, busy=0, Q holds 9, pass_cnt=1.
- Periodic wrap: limit=3, mode=1, start, run 12 edges -> Q sequence 0,1,2,3,0,1,2,3…; tc pulses 3 times spaced 4 cycles apart; pass_cnt=3; busy stays 1.
- Pause/stop: limit=9, mode=1. pause at Q=5 for 3 cycles -> Q holds 5, busy=1, tc=0; resumes 6 one edge after release. stop at Q=7 -> IDLE, Q=0, busy=0, no tc.
- Config gating and edges:
  - cfg_we limit=2 during RUN -> ignored; terminal still at 9.
  - limit=0 periodic -> tc high every cycle.
  - limit=15 -> 16-cycle period.
  - 20 periods -> pass_cnt saturates at 15.
- Collisions and async reset:
  - start+stop in DONE -> IDLE, done=0.
  - pause asserted on the terminal cycle -> tc delayed until resume.
  - CLEAR=0 mid-run at Q=6, asynchronously between edges -> all outputs reset immediately; limit_reg=9.
